// File: rtl/parser_pkg.sv
// ----------------------------------------------------------------------------
// parser_pkg
// Shared definitions for the parser front end:
//   - asm_state_t   : phv_assembler FSM states
//   - *_DEF         : default PHV / beat widths
//   - beats()       : number of input beats that make up one PHV
// ----------------------------------------------------------------------------
package parser_pkg;

   typedef enum logic [1:0] {
      ASM_IDLE    = 2'd0,
      ASM_COLLECT = 2'd1,
      ASM_DRAIN   = 2'd2
   } asm_state_t;

   localparam int PHV_WIDTH_DEF  = 1024;
   localparam int BEAT_WIDTH_DEF = 256;

   function automatic int beats(input int phv_width, input int beat_width);
      return phv_width / beat_width;
   endfunction

endpackage

// File: rtl/beat_byte_mask.sv
// ----------------------------------------------------------------------------
// beat_byte_mask
// Combinational byte-enable generator for one input beat. Byte 0 is the most
// significant byte of the beat; o_byte_en[b] enables byte b.
// Ports:
//   i_eop      : beat is the last beat of its packet
//   i_mod      : valid bytes on the eop beat (0 = all bytes valid)
//   o_byte_en  : per-byte enable, all ones unless eop with a non-zero mod
// ----------------------------------------------------------------------------
module beat_byte_mask
   import parser_pkg::*;
#(
   parameter int BEAT_WIDTH = BEAT_WIDTH_DEF,
   parameter int MOD_WIDTH  = $clog2(BEAT_WIDTH/8)
) (
   input  logic                    i_eop,
   input  logic [MOD_WIDTH-1:0]    i_mod,
   output logic [BEAT_WIDTH/8-1:0] o_byte_en
);

   localparam int BYTES = BEAT_WIDTH / 8;

   always_comb begin
      for (int b = 0; b < BYTES; b++) begin
         o_byte_en[b] = ~i_eop | (i_mod == '0) | (MOD_WIDTH'(b) < i_mod);
      end
   end

endmodule

// File: rtl/phv_assembler.sv
// ----------------------------------------------------------------------------
// phv_assembler
// Collects a beat-serial packet stream into one PHV_WIDTH-bit header vector.
// The first PHV_WIDTH bits of each packet become the PHV (packet byte 0 in the
// top byte); the rest of the packet is consumed and dropped. Valid/ready
// handshakes on both sides.
//
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_data_valid/_sop/_eop/_mod, i_data : beat-serial input stream
//   o_data_ready        : input beat accepted when valid & ready
//   o_phv_out_valid     : PHV available, held until i_phv_ready
//   i_phv_ready         : downstream accepts the PHV
//   o_phv_out           : assembled PHV
//   o_phv_trunc         : packet was longer than PHV_WIDTH bits
//   o_cnt_pkt/_trunc/_abort : statistics (only with PHV_ASM_CNT_EN defined)
//
// Build option: define PHV_ASM_CNT_EN to add the three 32-bit wrapping
// statistics counters and their output ports.
// ----------------------------------------------------------------------------
module phv_assembler
   import parser_pkg::*;
#(
   parameter int PHV_WIDTH  = PHV_WIDTH_DEF,
   parameter int BEAT_WIDTH = BEAT_WIDTH_DEF,
   parameter int MOD_WIDTH  = $clog2(BEAT_WIDTH/8)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_data_valid,
   input  logic                  i_data_sop,
   input  logic                  i_data_eop,
   input  logic [MOD_WIDTH-1:0]  i_data_mod,
   input  logic [BEAT_WIDTH-1:0] i_data,
   output logic                  o_data_ready,
   output logic                  o_phv_out_valid,
   input  logic                  i_phv_ready,
   output logic [PHV_WIDTH-1:0]  o_phv_out,
   output logic                  o_phv_trunc
`ifdef PHV_ASM_CNT_EN
   ,
   output logic [31:0]           o_cnt_pkt,
   output logic [31:0]           o_cnt_trunc,
   output logic [31:0]           o_cnt_abort
`endif
);

   localparam int BEATS = beats(PHV_WIDTH, BEAT_WIDTH);
   localparam int CNT_W = $clog2(BEATS) + 1;
   localparam int BYTES = BEAT_WIDTH / 8;
   localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS - 1);

   asm_state_t            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [PHV_WIDTH-1:0]  phv_q, phv_d;
   logic                  vld_q, vld_d;
   logic                  trunc_q, trunc_d;

   logic                  acc;
   logic                  emit;
   logic                  emit_trunc;
   logic                  wr_en;
   logic                  wr_clr;
   logic [CNT_W-1:0]      wr_slot;
   logic [BYTES-1:0]      byte_en;
   logic [BEAT_WIDTH-1:0] beat_m;

   beat_byte_mask #(
      .BEAT_WIDTH (BEAT_WIDTH),
      .MOD_WIDTH  (MOD_WIDTH)
   ) u_mask (
      .i_eop     (i_data_eop),
      .i_mod     (i_data_mod),
      .o_byte_en (byte_en)
   );

   always_comb begin
      for (int b = 0; b < BYTES; b++) begin
         beat_m[BEAT_WIDTH-1-8*b -: 8] = byte_en[b] ? i_data[BEAT_WIDTH-1-8*b -: 8] : 8'h00;
      end
   end

   // A pending PHV blocks every beat that would touch the buffer; tail beats
   // of a truncated packet never write it, so they may still flow.
   assign o_data_ready = ~vld_q | i_phv_ready | ((state_q == ASM_DRAIN) & ~i_data_sop);
   assign acc          = i_data_valid & o_data_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      emit       = 1'b0;
      emit_trunc = 1'b0;
      wr_en      = 1'b0;
      wr_clr     = 1'b0;
      wr_slot    = '0;
      if (acc) begin
         if (i_data_sop) begin
            // sop always restarts, whatever packet was in flight.
            wr_en  = 1'b1;
            wr_clr = 1'b1;
            if (i_data_eop) begin
               emit    = 1'b1;
               state_d = ASM_IDLE;
               cnt_d   = '0;
            end else if (BEATS == 1) begin
               emit       = 1'b1;
               emit_trunc = 1'b1;
               state_d    = ASM_DRAIN;
               cnt_d      = '0;
            end else begin
               state_d = ASM_COLLECT;
               cnt_d   = CNT_W'(1);
            end
         end else begin
            unique case (state_q)
               ASM_COLLECT: begin
                  wr_en   = 1'b1;
                  wr_slot = cnt_q;
                  cnt_d   = cnt_q + CNT_W'(1);
                  if (i_data_eop) begin
                     emit    = 1'b1;
                     state_d = ASM_IDLE;
                     cnt_d   = '0;
                  end else if (cnt_q == LAST_SLOT) begin
                     emit       = 1'b1;
                     emit_trunc = 1'b1;
                     state_d    = ASM_DRAIN;
                     cnt_d      = '0;
                  end
               end
               ASM_DRAIN: begin
                  if (i_data_eop) begin
                     state_d = ASM_IDLE;
                  end
               end
               default: begin
                  // Orphan beat in IDLE: consumed and dropped.
               end
            endcase
         end
      end
   end

   // The collection buffer doubles as the output register: buffer writes only
   // happen on accepted beats, and a non-drain beat is accepted only when no
   // PHV is pending or the pending one is taken on the same edge.
   always_comb begin
      phv_d = phv_q;
      if (wr_en) begin
         for (int k = 0; k < BEATS; k++) begin
            if (CNT_W'(k) == wr_slot) begin
               phv_d[PHV_WIDTH-1-k*BEAT_WIDTH -: BEAT_WIDTH] = beat_m;
            end else if (wr_clr) begin
               phv_d[PHV_WIDTH-1-k*BEAT_WIDTH -: BEAT_WIDTH] = '0;
            end
         end
      end
      vld_d   = (vld_q & ~i_phv_ready) | emit;
      trunc_d = emit ? emit_trunc : trunc_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ASM_IDLE;
         cnt_q   <= '0;
         phv_q   <= '0;
         vld_q   <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phv_q   <= phv_d;
         vld_q   <= vld_d;
         trunc_q <= trunc_d;
      end
   end

   assign o_phv_out_valid = vld_q;
   assign o_phv_out       = phv_q;
   assign o_phv_trunc     = trunc_q;

`ifdef PHV_ASM_CNT_EN
   logic [31:0] cnt_pkt_q, cnt_trunc_q, cnt_abort_q;
   logic        abort_inc;

   // sop cutting off a packet in flight, or a non-sop beat with no packet open.
   assign abort_inc = acc & (i_data_sop ? (state_q != ASM_IDLE) : (state_q == ASM_IDLE));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_pkt_q   <= '0;
         cnt_trunc_q <= '0;
         cnt_abort_q <= '0;
      end else begin
         cnt_pkt_q   <= cnt_pkt_q   + {31'd0, emit};
         cnt_trunc_q <= cnt_trunc_q + {31'd0, emit & emit_trunc};
         cnt_abort_q <= cnt_abort_q + {31'd0, abort_inc};
      end
   end

   assign o_cnt_pkt   = cnt_pkt_q;
   assign o_cnt_trunc = cnt_trunc_q;
   assign o_cnt_abort = cnt_abort_q;
`endif

endmodule
